lsu: RTL and testbench
======================

# lsu

Load/store unit in the memory stage, directly downstream of the ALU: takes the ALU's dedicated add result as the effective address of a load or store. It issues one request at a time on the data bus with a valid/ready request and a response-valid return, and stalls the pipeline while the access is outstanding. It aligns and sign/zero-extends load data into a registered writeback result. Misaligned accesses are trapped without touching the bus.

## Interface
- XLEN, 32, datapath width (only 32 supported)
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- ex_valid  in  1  execute-stage instruction valid
- ex_load  in  1  instruction is a load
- ex_store  in  1  instruction is a store (priority over ex_load if both high)
- ex_funct3  in  3  size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU; funct3[1:0]=11 treated as W
- ex_addr  in  XLEN  effective address (ALU add result)
- ex_wdata  in  XLEN  store data (rs2)
- ex_rd  in  5  load destination register
- lsu_stall  out  1  pipeline hold; high whenever state is not IDLE
- dbus_req  out  1  request valid
- dbus_we  out  1  1 = write
- dbus_addr  out  XLEN  word-aligned address ({ex_addr[31:2],2'b00})
- dbus_wstrb  out  4  byte enables (0 for reads)
- dbus_wdata  out  XLEN  lane-replicated store data
- dbus_ready  in  1  request accepted this cycle
- dbus_rvalid  in  1  read data valid
- dbus_rdata  in  XLEN  read data (full word)
- wb_valid  out  1  one-cycle load writeback pulse
- wb_rd  out  5  writeback register
- wb_data  out  XLEN  aligned, extended load data
- misalign_exc  out  1  one-cycle misaligned-access pulse
- misalign_store  out  1  1 = misaligned op was a store (valid with misalign_exc)
- misalign_addr  out  XLEN  faulting address (held until next exception)

## Operation
- FSM states: IDLE, REQ, WAIT. ex_* sampled only in IDLE; upstream holds its next instruction while lsu_stall=1.
- IDLE, mem op (ex_valid & (ex_load|ex_store)):
  - misaligned (H: addr[0]=1; W: addr[1:0]!=0) -> next cycle misalign_exc=1, misalign_store/misalign_addr set; stay IDLE; no bus request.
  - otherwise capture addr, funct3, rd, we, wstrb, wdata -> REQ.
- REQ: dbus_req=1, all dbus_* held stable until dbus_ready.
  - Store + ready -> IDLE.
  - Load + ready + rvalid in the same cycle -> complete as in WAIT, then IDLE.
  - Load + ready -> WAIT.
- WAIT: on dbus_rvalid, register wb_valid=1, wb_rd, wb_data -> IDLE. dbus_req=0 in WAIT.
- Load extract, off=addr[1:0]:
  - B/BU: byte rdata[8*off+:8], sign/zero extended.
  - H/HU: rdata[16*off[1]+:16], extended.
  - W: rdata.
- Store:
  - wstrb: B 4'b0001<<off, H 4'b0011<<off, W 4'b1111.
  - wdata: B {4{wdata[7:0]}}, H {2{wdata[15:0]}}, W wdata.
- rd=0 loads still pulse wb_valid; the register file discards x0 writes.
- dbus_rvalid outside WAIT/REQ-load is ignored. One access outstanding maximum.

## Timing
- Reset (async): state IDLE; every output 0 (dbus_req, dbus_we, dbus_addr, dbus_wstrb, dbus_wdata, wb_*, misalign_*, lsu_stall). Reset mid-access abandons it; the bus shares the same reset.
- All outputs are registered except lsu_stall, which is decoded from state.
- Accept at cycle 0 -> dbus_req high from cycle 1.
- Store with ready in cycle 1 -> lsu_stall low in cycle 2.
- Load with ready in cycle 1 and rvalid in cycle 2 -> wb_valid in cycle 3.
- Load with ready and rvalid together in cycle 1 -> wb_valid in cycle 2.
- Misaligned op at cycle 0 -> misalign_exc in cycle 1; lsu_stall never asserts.
- wb_valid and misalign_exc are single-cycle pulses; wb_data and wb_rd hold until the next load completes.
- Back-to-back: a new op is accepted in the first IDLE cycle after completion.

## Test plan
- LW addr 0x100, ready after 2 wait cycles, rdata 0xDEADBEEF -> dbus_addr 0x100, wstrb 0, wb_data 0xDEADBEEF, wb_rd correct, dbus_req stable throughout.
- LB at addr 0x103 and LBU at addr 0x103, rdata 0x80FF7F01 -> wb_data 0xFFFFFF80 then 0x00000080; LH at 0x102 -> 0xFFFF80FF.
- SB at 0x201 with wdata 0x12345678 -> dbus_addr 0x200, wstrb 0010, wdata 0x78787878, we=1, no wb_valid; SH at 0x202 -> wstrb 1100, wdata 0x56785678.
- LW at 0x102 and SH at 0x301 -> misalign_exc pulse, misalign_addr 0x102 (then 0x301), misalign_store 0 then 1, dbus_req never high.
- Load with ready and rvalid in the same cycle, followed immediately by a store -> wb_valid next cycle; store request issued without a dropped cycle.
- rst asserted while in WAIT -> all outputs 0 immediately; a late rvalid is ignored; the next load completes normally.

Source files
------------

// File: rtl/lsu.sv
// Memory-stage load/store unit: one outstanding data-bus access, load alignment and
// sign/zero extension into a registered writeback, misaligned accesses trapped off-bus.
module lsu #(
  parameter int XLEN = 32
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_ex_valid,
  input  logic            i_ex_load,
  input  logic            i_ex_store,
  input  logic [2:0]      i_ex_funct3,
  input  logic [XLEN-1:0] i_ex_addr,
  input  logic [XLEN-1:0] i_ex_wdata,
  input  logic [4:0]      i_ex_rd,
  output logic            o_lsu_stall,
  output logic            o_dbus_req,
  output logic            o_dbus_we,
  output logic [XLEN-1:0] o_dbus_addr,
  output logic [3:0]      o_dbus_wstrb,
  output logic [XLEN-1:0] o_dbus_wdata,
  input  logic            i_dbus_ready,
  input  logic            i_dbus_rvalid,
  input  logic [XLEN-1:0] i_dbus_rdata,
  output logic            o_wb_valid,
  output logic [4:0]      o_wb_rd,
  output logic [XLEN-1:0] o_wb_data,
  output logic            o_misalign_exc,
  output logic            o_misalign_store,
  output logic [XLEN-1:0] o_misalign_addr
);

  // state  | meaning
  // S_IDLE | ready to sample ex_*; no access outstanding
  // S_REQ  | request driven on the bus, waiting for dbus_ready
  // S_WAIT | load accepted by the bus, waiting for dbus_rvalid
  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic            r_dbus_req;
  logic            r_dbus_we;
  logic [XLEN-1:0] r_dbus_addr;
  logic [3:0]      r_dbus_wstrb;
  logic [XLEN-1:0] r_dbus_wdata;
  logic [1:0]      r_off;
  logic [2:0]      r_funct3;
  logic [4:0]      r_rd;
  logic            r_wb_valid;
  logic [4:0]      r_wb_rd;
  logic [XLEN-1:0] r_wb_data;
  logic            r_misalign_exc;
  logic            r_misalign_store;
  logic [XLEN-1:0] r_misalign_addr;

  logic            w_mem_op;
  logic            w_misalign;
  logic            w_accept;
  logic            w_trap;
  logic            w_req_done;
  logic            w_load_done;
  logic [3:0]      w_wstrb;
  logic [XLEN-1:0] w_wdata;

  function automatic logic [XLEN-1:0] f_extract(input logic [XLEN-1:0] d,
                                                input logic [1:0] off,
                                                input logic [2:0] f3);
    logic [7:0]  b;
    logic [15:0] h;
    logic [XLEN-1:0] res;
    case (off)
      2'd0:    b = d[7:0];
      2'd1:    b = d[15:8];
      2'd2:    b = d[23:16];
      default: b = d[31:24];
    endcase
    h = off[1] ? d[31:16] : d[15:0];
    case (f3[1:0])
      2'b00:   res = f3[2] ? {24'b0, b} : {{24{b[7]}}, b};
      2'b01:   res = f3[2] ? {16'b0, h} : {{16{h[15]}}, h};
      default: res = d;
    endcase
    return res;
  endfunction

  always_comb begin
    w_mem_op   = i_ex_valid & (i_ex_load | i_ex_store);
    w_misalign = 1'b0;
    w_wstrb    = 4'b1111;
    w_wdata    = i_ex_wdata;
    case (i_ex_funct3[1:0])
      2'b00: begin
        w_wstrb = 4'b0001 << i_ex_addr[1:0];
        w_wdata = {4{i_ex_wdata[7:0]}};
      end
      2'b01: begin
        w_misalign = i_ex_addr[0];
        w_wstrb    = 4'b0011 << i_ex_addr[1:0];
        w_wdata    = {2{i_ex_wdata[15:0]}};
      end
      default: w_misalign = (i_ex_addr[1:0] != 2'b00);
    endcase
    w_accept    = (r_state == S_IDLE) & w_mem_op & ~w_misalign;
    w_trap      = (r_state == S_IDLE) & w_mem_op & w_misalign;
    w_req_done  = (r_state == S_REQ) & i_dbus_ready;
    // a load may see its data in the very cycle the request is accepted
    w_load_done = ((r_state == S_REQ) & i_dbus_ready & ~r_dbus_we & i_dbus_rvalid) |
                  ((r_state == S_WAIT) & i_dbus_rvalid);
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_accept) w_state_nxt = S_REQ;
      S_REQ: begin
        if (i_dbus_ready)
          w_state_nxt = (r_dbus_we | i_dbus_rvalid) ? S_IDLE : S_WAIT;
      end
      S_WAIT: if (i_dbus_rvalid) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_dbus_req       <= 1'b0;
      r_dbus_we        <= 1'b0;
      r_dbus_addr      <= '0;
      r_dbus_wstrb     <= 4'b0;
      r_dbus_wdata     <= '0;
      r_off            <= 2'b0;
      r_funct3         <= 3'b0;
      r_rd             <= 5'b0;
      r_wb_valid       <= 1'b0;
      r_wb_rd          <= 5'b0;
      r_wb_data        <= '0;
      r_misalign_exc   <= 1'b0;
      r_misalign_store <= 1'b0;
      r_misalign_addr  <= '0;
    end else begin
      r_wb_valid     <= 1'b0;
      r_misalign_exc <= 1'b0;
      if (w_accept) begin
        r_dbus_req   <= 1'b1;
        r_dbus_we    <= i_ex_store;
        r_dbus_addr  <= {i_ex_addr[XLEN-1:2], 2'b00};
        r_dbus_wstrb <= i_ex_store ? w_wstrb : 4'b0;
        r_dbus_wdata <= i_ex_store ? w_wdata : '0;
        r_off        <= i_ex_addr[1:0];
        r_funct3     <= i_ex_funct3;
        r_rd         <= i_ex_rd;
      end
      if (w_trap) begin
        r_misalign_exc   <= 1'b1;
        r_misalign_store <= i_ex_store;
        r_misalign_addr  <= i_ex_addr;
      end
      if (w_req_done) r_dbus_req <= 1'b0;
      if (w_load_done) begin
        r_wb_valid <= 1'b1;
        r_wb_rd    <= r_rd;
        r_wb_data  <= f_extract(i_dbus_rdata, r_off, r_funct3);
      end
    end
  end

  assign o_lsu_stall      = (r_state != S_IDLE);
  assign o_dbus_req       = r_dbus_req;
  assign o_dbus_we        = r_dbus_we;
  assign o_dbus_addr      = r_dbus_addr;
  assign o_dbus_wstrb     = r_dbus_wstrb;
  assign o_dbus_wdata     = r_dbus_wdata;
  assign o_wb_valid       = r_wb_valid;
  assign o_wb_rd          = r_wb_rd;
  assign o_wb_data        = r_wb_data;
  assign o_misalign_exc   = r_misalign_exc;
  assign o_misalign_store = r_misalign_store;
  assign o_misalign_addr  = r_misalign_addr;

endmodule

// File: tb/tb_lsu.sv
// Directed-vector bench for lsu: table of load/store/misaligned ops with hand-computed
// results, plus a reset-during-WAIT sequence.
module tb_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid, ex_load, ex_store;
  logic [2:0]  ex_funct3;
  logic [31:0] ex_addr, ex_wdata;
  logic [4:0]  ex_rd;
  logic        lsu_stall, dbus_req, dbus_we;
  logic [31:0] dbus_addr, dbus_wdata;
  logic [3:0]  dbus_wstrb;
  logic        dbus_ready, dbus_rvalid;
  logic [31:0] dbus_rdata;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        misalign_exc, misalign_store;
  logic [31:0] misalign_addr;

  lsu #(.XLEN(32)) dut (
    .i_clk(clk), .i_rst(rst),
    .i_ex_valid(ex_valid), .i_ex_load(ex_load), .i_ex_store(ex_store),
    .i_ex_funct3(ex_funct3), .i_ex_addr(ex_addr), .i_ex_wdata(ex_wdata), .i_ex_rd(ex_rd),
    .o_lsu_stall(lsu_stall), .o_dbus_req(dbus_req), .o_dbus_we(dbus_we),
    .o_dbus_addr(dbus_addr), .o_dbus_wstrb(dbus_wstrb), .o_dbus_wdata(dbus_wdata),
    .i_dbus_ready(dbus_ready), .i_dbus_rvalid(dbus_rvalid), .i_dbus_rdata(dbus_rdata),
    .o_wb_valid(wb_valid), .o_wb_rd(wb_rd), .o_wb_data(wb_data),
    .o_misalign_exc(misalign_exc), .o_misalign_store(misalign_store),
    .o_misalign_addr(misalign_addr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        st;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [4:0]  rd;
    int          rdy_dly;
    int          rv_dly;
    logic        mis;
    logic [31:0] exp_daddr;
    logic [3:0]  exp_wstrb;
    logic [31:0] exp_wdata;
    logic [31:0] exp_wb;
  } vec_t;

  vec_t        vecs[$];
  int          n_vec = 0;
  int          n_chk = 0;
  int          n_err = 0;
  logic [31:0] last_wb = 32'h0;

  function automatic vec_t mk(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [31:0] rdata,
                              input logic [4:0] rd, input int rdy_dly, input int rv_dly,
                              input logic mis, input logic [31:0] exp_daddr,
                              input logic [3:0] exp_wstrb, input logic [31:0] exp_wdata,
                              input logic [31:0] exp_wb);
    vec_t v;
    v.st = st; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.rdata = rdata; v.rd = rd;
    v.rdy_dly = rdy_dly; v.rv_dly = rv_dly; v.mis = mis; v.exp_daddr = exp_daddr;
    v.exp_wstrb = exp_wstrb; v.exp_wdata = exp_wdata; v.exp_wb = exp_wb;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_stall"}, {31'b0, lsu_stall}, 32'h0);
    chk({tag, "_req"}, {31'b0, dbus_req}, 32'h0);
    chk({tag, "_we"}, {31'b0, dbus_we}, 32'h0);
    chk({tag, "_daddr"}, dbus_addr, 32'h0);
    chk({tag, "_wstrb"}, {28'b0, dbus_wstrb}, 32'h0);
    chk({tag, "_dwdata"}, dbus_wdata, 32'h0);
    chk({tag, "_wbv"}, {31'b0, wb_valid}, 32'h0);
    chk({tag, "_wbrd"}, {27'b0, wb_rd}, 32'h0);
    chk({tag, "_wbdata"}, wb_data, 32'h0);
    chk({tag, "_mexc"}, {31'b0, misalign_exc}, 32'h0);
    chk({tag, "_mst"}, {31'b0, misalign_store}, 32'h0);
    chk({tag, "_maddr"}, misalign_addr, 32'h0);
  endtask

  // Called at a negedge with the LSU idle; returns at the first idle negedge after the op.
  task automatic run_vec(input vec_t v);
    chk("idle_stall", {31'b0, lsu_stall}, 32'h0);
    ex_valid = 1'b1; ex_load = ~v.st; ex_store = v.st; ex_funct3 = v.f3;
    ex_addr = v.addr; ex_wdata = v.wdata; ex_rd = v.rd;
    @(negedge clk);
    ex_valid = 1'b0; ex_load = 1'b0; ex_store = 1'b0;
    chk("wb_pulse_clear", {31'b0, wb_valid}, 32'h0);
    if (v.mis) begin
      chk("mis_exc", {31'b0, misalign_exc}, 32'h1);
      chk("mis_store", {31'b0, misalign_store}, {31'b0, v.st});
      chk("mis_addr", misalign_addr, v.addr);
      chk("mis_no_req", {31'b0, dbus_req}, 32'h0);
      chk("mis_no_stall", {31'b0, lsu_stall}, 32'h0);
      return;
    end
    chk("exc_pulse_clear", {31'b0, misalign_exc}, 32'h0);
    chk("req", {31'b0, dbus_req}, 32'h1);
    chk("we", {31'b0, dbus_we}, {31'b0, v.st});
    chk("daddr", dbus_addr, v.exp_daddr);
    chk("wstrb", {28'b0, dbus_wstrb}, {28'b0, v.exp_wstrb});
    if (v.st) chk("dwdata", dbus_wdata, v.exp_wdata);
    for (int i = 0; i < v.rdy_dly; i++) begin
      @(negedge clk);
      chk("hold_req", {31'b0, dbus_req}, 32'h1);
      chk("hold_stall", {31'b0, lsu_stall}, 32'h1);
      chk("hold_daddr", dbus_addr, v.exp_daddr);
      chk("hold_wstrb", {28'b0, dbus_wstrb}, {28'b0, v.exp_wstrb});
      chk("hold_we", {31'b0, dbus_we}, {31'b0, v.st});
      if (v.st) chk("hold_dwdata", dbus_wdata, v.exp_wdata);
    end
    dbus_ready = 1'b1;
    if (!v.st && v.rv_dly == 0) begin
      dbus_rvalid = 1'b1;
      dbus_rdata  = v.rdata;
    end
    @(negedge clk);
    dbus_ready = 1'b0; dbus_rvalid = 1'b0;
    if (v.st) begin
      chk("st_done_stall", {31'b0, lsu_stall}, 32'h0);
      chk("st_done_req", {31'b0, dbus_req}, 32'h0);
      chk("st_no_wb", {31'b0, wb_valid}, 32'h0);
      chk("st_wb_hold", wb_data, last_wb);
    end else begin
      if (v.rv_dly > 0) begin
        chk("wait_stall", {31'b0, lsu_stall}, 32'h1);
        chk("wait_no_req", {31'b0, dbus_req}, 32'h0);
        chk("wait_no_wb", {31'b0, wb_valid}, 32'h0);
        for (int i = 1; i < v.rv_dly; i++) begin
          @(negedge clk);
          chk("wait_stall2", {31'b0, lsu_stall}, 32'h1);
        end
        dbus_rvalid = 1'b1;
        dbus_rdata  = v.rdata;
        @(negedge clk);
        dbus_rvalid = 1'b0;
      end
      chk("wb_valid", {31'b0, wb_valid}, 32'h1);
      chk("wb_data", wb_data, v.exp_wb);
      chk("wb_rd", {27'b0, wb_rd}, {27'b0, v.rd});
      chk("ld_done_stall", {31'b0, lsu_stall}, 32'h0);
      last_wb = v.exp_wb;
    end
  endtask

  initial begin
    rst = 1'b1;
    ex_valid = 1'b0; ex_load = 1'b0; ex_store = 1'b0; ex_funct3 = 3'b0;
    ex_addr = 32'h0; ex_wdata = 32'h0; ex_rd = 5'h0;
    dbus_ready = 1'b0; dbus_rvalid = 1'b0; dbus_rdata = 32'h0;

    //                st    f3      addr          wdata         rdata         rd  rdy rv mis daddr         wstrb    exp_wdata     exp_wb
    vecs.push_back(mk(1'b0, 3'b010, 32'h0000_0100, 32'h0,        32'hDEAD_BEEF, 5,  2, 1, 0, 32'h0000_0100, 4'b0000, 32'h0,        32'hDEAD_BEEF));
    vecs.push_back(mk(1'b0, 3'b000, 32'h0000_0103, 32'h0,        32'h80FF_7F01, 7,  0, 1, 0, 32'h0000_0100, 4'b0000, 32'h0,        32'hFFFF_FF80));
    vecs.push_back(mk(1'b0, 3'b100, 32'h0000_0103, 32'h0,        32'h80FF_7F01, 8,  0, 2, 0, 32'h0000_0100, 4'b0000, 32'h0,        32'h0000_0080));
    vecs.push_back(mk(1'b0, 3'b001, 32'h0000_0102, 32'h0,        32'h80FF_7F01, 9,  1, 1, 0, 32'h0000_0100, 4'b0000, 32'h0,        32'hFFFF_80FF));
    vecs.push_back(mk(1'b1, 3'b000, 32'h0000_0201, 32'h1234_5678, 32'h0,        1,  0, 0, 0, 32'h0000_0200, 4'b0010, 32'h7878_7878, 32'h0));
    vecs.push_back(mk(1'b1, 3'b001, 32'h0000_0202, 32'h1234_5678, 32'h0,        1,  1, 0, 0, 32'h0000_0200, 4'b1100, 32'h5678_5678, 32'h0));
    vecs.push_back(mk(1'b0, 3'b010, 32'h0000_0102, 32'h0,        32'h0,        2,  0, 0, 1, 32'h0,        4'b0000, 32'h0,        32'h0));
    vecs.push_back(mk(1'b1, 3'b001, 32'h0000_0301, 32'hFFFF_FFFF, 32'h0,        2,  0, 0, 1, 32'h0,        4'b0000, 32'h0,        32'h0));
    vecs.push_back(mk(1'b0, 3'b001, 32'h0000_0100, 32'h0,        32'h0000_8001, 10, 0, 1, 0, 32'h0000_0100, 4'b0000, 32'h0,        32'hFFFF_8001));
    vecs.push_back(mk(1'b0, 3'b101, 32'h0000_0100, 32'h0,        32'hFFFF_8001, 11, 0, 1, 0, 32'h0000_0100, 4'b0000, 32'h0,        32'h0000_8001));
    vecs.push_back(mk(1'b0, 3'b000, 32'h0000_0101, 32'h0,        32'h0000_7F00, 0,  0, 1, 0, 32'h0000_0100, 4'b0000, 32'h0,        32'h0000_007F));
    vecs.push_back(mk(1'b0, 3'b100, 32'h0000_0102, 32'h0,        32'h00AB_0000, 12, 0, 1, 0, 32'h0000_0100, 4'b0000, 32'h0,        32'h0000_00AB));
    vecs.push_back(mk(1'b0, 3'b001, 32'h0000_0101, 32'h0,        32'h0,        3,  0, 0, 1, 32'h0,        4'b0000, 32'h0,        32'h0));
    vecs.push_back(mk(1'b1, 3'b010, 32'h0000_0404, 32'hA5A5_0F0F, 32'h0,        1,  1, 0, 0, 32'h0000_0404, 4'b1111, 32'hA5A5_0F0F, 32'h0));
    vecs.push_back(mk(1'b1, 3'b000, 32'h0000_0203, 32'h0000_00C3, 32'h0,        1,  0, 0, 0, 32'h0000_0200, 4'b1000, 32'hC3C3_C3C3, 32'h0));
    // same-cycle ready+rvalid load, then a store accepted in the very next (idle) cycle
    vecs.push_back(mk(1'b0, 3'b011, 32'h0000_0108, 32'h0,        32'h1122_3344, 13, 0, 0, 0, 32'h0000_0108, 4'b0000, 32'h0,        32'h1122_3344));
    vecs.push_back(mk(1'b1, 3'b010, 32'h0000_0600, 32'h0BAD_CAFE, 32'h0,        1,  0, 0, 0, 32'h0000_0600, 4'b1111, 32'h0BAD_CAFE, 32'h0));
    vecs.push_back(mk(1'b0, 3'b000, 32'h0000_0100, 32'h0,        32'h0000_00FE, 14, 0, 0, 0, 32'h0000_0100, 4'b0000, 32'h0,        32'hFFFF_FFFE));

    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    n_vec++;
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < vecs.size(); i++) begin
      run_vec(vecs[i]);
      n_vec++;
    end

    // reset while a load sits in WAIT; a late rvalid must be ignored
    ex_valid = 1'b1; ex_load = 1'b1; ex_store = 1'b0; ex_funct3 = 3'b010;
    ex_addr = 32'h0000_0500; ex_rd = 5'd4;
    @(negedge clk);
    ex_valid = 1'b0; ex_load = 1'b0;
    dbus_ready = 1'b1;
    @(negedge clk);
    dbus_ready = 1'b0;
    chk("rstseq_in_wait", {31'b0, lsu_stall}, 32'h1);
    #1 rst = 1'b1;
    #1 chk_all_zero("rst_wait");
    last_wb = 32'h0;
    @(negedge clk);
    rst = 1'b0;
    dbus_rvalid = 1'b1; dbus_rdata = 32'h5555_AAAA;
    @(negedge clk);
    dbus_rvalid = 1'b0;
    chk("late_rvalid_wbv", {31'b0, wb_valid}, 32'h0);
    chk("late_rvalid_stall", {31'b0, lsu_stall}, 32'h0);
    chk("late_rvalid_wbdata", wb_data, 32'h0);
    n_vec++;
    run_vec(mk(1'b0, 3'b010, 32'h0000_0504, 32'h0, 32'h7654_3210, 6, 1, 1, 0,
               32'h0000_0504, 4'b0000, 32'h0, 32'h7654_3210));
    n_vec++;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit, got running expected finished");
    $fatal(1);
  end

endmodule
